// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared constants for the ALU command sequencer: opcodes, command kinds, FSM encodings.
package alu_cmd_sequencer_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LOAD = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_ADD  = 4'd7;
  localparam logic [3:0] OP_MULT = 4'd8;

  localparam logic [1:0] K_OP      = 2'd0;
  localparam logic [1:0] K_PWR_ON  = 2'd1;
  localparam logic [1:0] K_PWR_OFF = 2'd2;
  localparam logic [1:0] K_ALU_RST = 2'd3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_MULT;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_fifo.sv
// Synchronous command FIFO with combinational head read-out.
module cmd_fifo #(
  parameter int W     = 14,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [W-1:0]              wdata,
  output logic [W-1:0]              rdata,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]             count_q, count_d;
  logic                    do_push, do_pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  // A full FIFO refuses a push even when the head is popped on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Front end for the accumulator ALU: queues host commands, pulses the ALU, returns results.
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_kind,
  input  logic [3:0]   cmd_op,
  input  logic [N-1:0] cmd_data,
  output logic [3:0]   alu_op,
  output logic [N-1:0] alu_in,
  output logic         alu_on,
  output logic         alu_off,
  output logic         alu_rst,
  input  logic [N-1:0] alu_out,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic [3:0]   res_op,
  output logic         res_err,
  output logic         pwr_state,
  output logic         busy
);
  localparam int EW = 2 + 4 + N;

  logic [EW-1:0]          head;
  logic                   full, empty;
  logic [$clog2(DEPTH):0] count;
  logic [1:0]             h_kind;
  logic [3:0]             h_op;
  logic [N-1:0]           h_data;
  logic                   go, issue, cap;

  logic [1:0]   state_q, state_d;
  logic [1:0]   cur_kind_q, cur_kind_d;
  logic [3:0]   cur_op_q, cur_op_d;
  logic [3:0]   alu_op_q, alu_op_d;
  logic [N-1:0] alu_in_q, alu_in_d;
  logic         alu_on_q, alu_on_d, alu_off_q, alu_off_d, alu_rst_q, alu_rst_d;
  logic         pwr_q, pwr_d;
  logic         res_valid_q, res_valid_d, res_err_q, res_err_d;
  logic [N-1:0] res_data_q, res_data_d;
  logic [3:0]   res_op_q, res_op_d;

  cmd_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid && cmd_ready),
    .pop   (go),
    .wdata ({cmd_kind, cmd_op, cmd_data}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign {h_kind, h_op, h_data} = head;
  assign issue = (state_q == S_ISSUE);
  // ISSUE is never followed directly by ISSUE, which enforces the one-command-per-two-cycles rate.
  assign go    = !empty && (!res_valid_q || res_ready) && !issue;
  assign cap   = issue && (cur_kind_q == K_OP) && (cur_op_q != OP_NOP);

  always_comb begin
    state_d    = go ? S_ISSUE : (issue ? S_GAP : S_IDLE);
    cur_kind_d = go ? h_kind : cur_kind_q;
    cur_op_d   = go ? h_op   : cur_op_q;
    alu_op_d   = OP_NOP;
    alu_in_d   = '0;
    alu_on_d   = 1'b0;
    alu_off_d  = 1'b0;
    alu_rst_d  = 1'b0;
    if (go) begin
      case (h_kind)
        K_OP: if (op_legal(h_op) && pwr_q) begin
          alu_op_d = h_op;
          alu_in_d = h_data;
        end
        K_PWR_ON:  alu_on_d  = 1'b1;
        K_PWR_OFF: alu_off_d = 1'b1;
        default:   alu_rst_d = 1'b1;
      endcase
    end
  end

  always_comb begin
    pwr_d = pwr_q;
    if (issue) begin
      case (cur_kind_q)
        K_PWR_ON, K_ALU_RST: pwr_d = 1'b1;
        K_PWR_OFF:           pwr_d = 1'b0;
        default:             pwr_d = pwr_q;
      endcase
    end
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    res_err_d   = res_err_q;
    if (res_valid_q && res_ready) res_valid_d = 1'b0;
    if (cap) begin
      res_valid_d = 1'b1;
      res_op_d    = cur_op_q;
      res_err_d   = !(op_legal(cur_op_q) && pwr_q);
      res_data_d  = res_err_d ? '0 : alu_out;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cur_kind_q  <= K_OP;
      cur_op_q    <= OP_NOP;
      alu_op_q    <= OP_NOP;
      alu_in_q    <= '0;
      alu_on_q    <= 1'b0;
      alu_off_q   <= 1'b0;
      alu_rst_q   <= 1'b0;
      pwr_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_kind_q  <= cur_kind_d;
      cur_op_q    <= cur_op_d;
      alu_op_q    <= alu_op_d;
      alu_in_q    <= alu_in_d;
      alu_on_q    <= alu_on_d;
      alu_off_q   <= alu_off_d;
      alu_rst_q   <= alu_rst_d;
      pwr_q       <= pwr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      res_err_q   <= res_err_d;
    end
  end

  assign cmd_ready = !full;
  assign busy      = (count != '0) || (state_q != S_IDLE);
  assign alu_op    = alu_op_q;
  assign alu_in    = alu_in_q;
  assign alu_on    = alu_on_q;
  assign alu_off   = alu_off_q;
  assign alu_rst   = alu_rst_q;
  assign pwr_state = pwr_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_op    = res_op_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer driving a small accumulator ALU stand-in.
module tb_alu_cmd_sequencer;
  import alu_cmd_sequencer_pkg::*;
  localparam int N = 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic         err;
    logic [3:0]   op;
    logic [N-1:0] data;
  } res_t;

  logic clk = 1'b0, rst = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, res_ready = 1'b1;
  logic [1:0] cmd_kind = '0;
  logic [3:0] cmd_op = '0;
  logic [N-1:0] cmd_data = '0;
  logic [3:0] alu_op, res_op;
  logic [N-1:0] alu_in, alu_out, res_data, acc;
  logic alu_on, alu_off, alu_rst, res_valid, res_err, pwr_state, busy;

  int tests = 0, fails = 0, cyc = 0;
  int rst_hi_cnt = 0, add_cnt = 0, op_cnt = 0;
  int pulse_cyc[$];
  res_t sb[$];

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kind(cmd_kind), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .alu_op(alu_op), .alu_in(alu_in), .alu_on(alu_on), .alu_off(alu_off),
    .alu_rst(alu_rst), .alu_out(alu_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_op(res_op),
    .res_err(res_err), .pwr_state(pwr_state), .busy(busy)
  );

  // Accumulator ALU stand-in: combinational result, accumulator updates on each non-NOP op.
  always_comb begin
    alu_out = acc;
    case (alu_op)
      OP_LOAD: alu_out = alu_in;
      OP_NOT:  alu_out = ~acc;
      OP_XOR:  alu_out = acc ^ alu_in;
      OP_OR:   alu_out = acc | alu_in;
      OP_AND:  alu_out = acc & alu_in;
      OP_SUB:  alu_out = acc - alu_in;
      OP_ADD:  alu_out = acc + alu_in;
      OP_MULT: alu_out = acc * alu_in;
      default: alu_out = acc;
    endcase
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (alu_rst) acc <= '0;
    else if (alu_op != OP_NOP) acc <= alu_out;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a result is accepted, and logs ALU pulses.
  always @(negedge clk) begin
    if (rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got err=%0b op=%0h data=%0h expected none",
                 res_err, res_op, res_data);
      end else begin
        res_t e;
        e = sb.pop_front();
        chk("result", {19'd0, res_err, res_op, res_data}, {19'd0, e});
      end
    end
    if (alu_op != OP_NOP || alu_on || alu_off || alu_rst) pulse_cyc.push_back(cyc);
    if (alu_rst) rst_hi_cnt++;
    if (alu_op == OP_ADD) add_cnt++;
    if (alu_op != OP_NOP) op_cnt++;
  end

  task automatic push_cmd(input logic [1:0] k, input logic [3:0] o, input logic [N-1:0] d);
    int t;
    t = 0;
    cmd_valid = 1'b1; cmd_kind = k; cmd_op = o; cmd_data = d;
    while (1) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk); #1;
        break;
      end
      t++;
      if (t > 200) begin
        chk("push_timeout_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic expect_res(input logic err, input logic [3:0] o, input logic [N-1:0] d);
    sb.push_back('{err: err, op: o, data: d});
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (!(sb.size() == 0 && !busy && !res_valid)) begin
      @(negedge clk);
      t++;
      if (t > 300) begin
        chk("drain_pending", sb.size(), 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    #12;
    chk("rst_alu_op", alu_op, OP_NOP);
    chk("rst_alu_in", alu_in, 0);
    chk("rst_pulses", {alu_on, alu_off, alu_rst}, 0);
    chk("rst_res", {res_valid, res_err, res_op, res_data}, 0);
    chk("rst_pwr", pwr_state, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // 1: reset pulse, LOAD, ADD back-to-back
    pulse_cyc.delete();
    rst_hi_cnt = 0;
    push_cmd(K_ALU_RST, OP_NOP, 8'h00);
    expect_res(1'b0, OP_LOAD, 8'h05);
    push_cmd(K_OP, OP_LOAD, 8'h05);
    expect_res(1'b0, OP_ADD, 8'h08);
    push_cmd(K_OP, OP_ADD, 8'h03);
    drain();
    chk("t1_alu_rst_width", rst_hi_cnt, 1);
    chk("t1_pulse_count", pulse_cyc.size(), 3);
    if (pulse_cyc.size() == 3) begin
      chk("t1_gap0", pulse_cyc[1] - pulse_cyc[0], 2);
      chk("t1_gap1", pulse_cyc[2] - pulse_cyc[1], 2);
    end
    chk("t1_pwr", pwr_state, 1);

    // 2: op while powered off is an error; power back on resumes accumulation
    add_cnt = 0;
    push_cmd(K_PWR_OFF, OP_NOP, 8'h00);
    expect_res(1'b1, OP_ADD, 8'h00);
    push_cmd(K_OP, OP_ADD, 8'h10);
    drain();
    chk("t2_no_add_when_off", add_cnt, 0);
    chk("t2_pwr_off", pwr_state, 0);
    push_cmd(K_PWR_ON, OP_NOP, 8'h00);
    expect_res(1'b0, OP_ADD, 8'h0A);
    push_cmd(K_OP, OP_ADD, 8'h02);
    drain();
    chk("t2_pwr_on", pwr_state, 1);

    // 3: illegal opcode
    op_cnt = 0;
    expect_res(1'b1, 4'hA, 8'h00);
    push_cmd(K_OP, 4'hA, 8'h77);
    drain();
    chk("t3_no_pulse", op_cnt, 0);

    // 4: back-pressure fills the FIFO, then drains in order
    res_ready = 1'b0;
    op_cnt = 0;
    for (int i = 0; i < 6; i++) expect_res(1'b0, OP_LOAD, 8'(8'h11 + i));
    fork
      for (int i = 0; i < 6; i++) push_cmd(K_OP, OP_LOAD, 8'(8'h11 + i));
    join_none
    repeat (20) @(negedge clk);
    chk("t4_cmd_ready_full", cmd_ready, 0);
    chk("t4_res_stalled", res_valid, 1);
    chk("t4_busy", busy, 1);
    chk("t4_one_issue", op_cnt, 1);
    chk("t4_held_data", res_data, 8'h11);
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait fork;
    drain();
    chk("t4_all_issued", op_cnt, 6);

    // 5: async reset while alu_on is being pulsed, with a command queued behind it
    fork
      begin
        push_cmd(K_PWR_ON, OP_NOP, 8'h00);
        push_cmd(K_OP, OP_LOAD, 8'h33);
      end
    join_none
    t = 0;
    while (!alu_on && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("t5_saw_alu_on", alu_on, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_alu_on_cut", alu_on, 0);
    chk("t5_res_valid", res_valid, 0);
    chk("t5_busy_flushed", busy, 0);
    chk("t5_cmd_ready", cmd_ready, 1);
    chk("t5_pwr", pwr_state, 0);
    wait fork;
    @(posedge clk); #1;
    rst = 1'b1;

    // 6: multiply wraps, subtract underflows
    push_cmd(K_PWR_ON, OP_NOP, 8'h00);
    expect_res(1'b0, OP_LOAD, 8'h20);
    push_cmd(K_OP, OP_LOAD, 8'h20);
    expect_res(1'b0, OP_MULT, 8'h00);
    push_cmd(K_OP, OP_MULT, 8'h10);
    expect_res(1'b0, OP_SUB, 8'hFF);
    push_cmd(K_OP, OP_SUB, 8'h01);
    drain();
    chk("t6_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Command-issuing front end for the accumulator ALU. It buffers host commands in a small FIFO and drives the ALU's op/in/on/off/rst inputs with one-cycle command pulses. It captures each result-producing operation's ALU output and returns it to the host on a valid/ready result port. It owns the command side of the ALU interface and tracks a shadow power state.

Parameters:
N, 8, data width; must match the ALU width.
DEPTH, 4, command FIFO depth; must be a power of two, at least 2.

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  FIFO not full
cmd_kind  in  2  0=OP, 1=PWR_ON, 2=PWR_OFF, 3=ALU_RESET
cmd_op  in  4  ALU opcode; used only for OP
cmd_data  in  N  operand; used only for OP
alu_op  out  4  opcode to ALU
alu_in  out  N  operand to ALU
alu_on  out  1  ALU power-on pulse
alu_off  out  1  ALU power-off pulse
alu_rst  out  1  ALU synchronous reset pulse, active-high
alu_out  in  N  ALU combinational result
res_valid  out  1  result available
res_ready  in  1  host accepts result
res_data  out  N  captured result
res_op  out  4  opcode that produced the result
res_err  out  1  result is an error marker; res_data=0
pwr_state  out  1  shadow ALU power state
busy  out  1  FIFO non-empty or FSM not in IDLE

Behaviour:
- Reset (rst=0, async): FIFO empty; FSM in IDLE. alu_op=0000 (NOP), alu_in=0, alu_on/alu_off/alu_rst=0. res_valid=0, res_data=0, res_op=0, res_err=0, pwr_state=0, cmd_ready=1.
- Opcodes: NOP=0, LOAD=1, NOT=2, XOR=3, OR=4, AND=5, SUB=6, ADD=7, MULT=8. Codes 9–15 are illegal.
- FIFO push: on cmd_valid && cmd_ready. cmd_ready = (count != DEPTH) and depends on count only. When full, a push is refused even if a pop happens in the same cycle.
- All ALU-side outputs are registered. Idle values are driven in every cycle except ISSUE.
- FSM states: IDLE, ISSUE, GAP.
  - IDLE/GAP → ISSUE when FIFO is non-empty and (!res_valid || res_ready). The head entry is popped on that edge. Otherwise the FSM stays in, or returns to, IDLE.
  - ISSUE → GAP, unconditionally.
- ISSUE cycle drive, per command kind:
  - OP, legal, pwr_state=1: alu_op=cmd_op, alu_in=cmd_data.
  - PWR_ON: alu_on=1; pwr_state←1 at the end of ISSUE.
  - PWR_OFF: alu_off=1; pwr_state←0.
  - ALU_RESET: alu_rst=1; pwr_state←1.
  - OP that is illegal, or issued with pwr_state=0: no ALU pulse; idle values stay on the ALU outputs.
- Result capture happens at the edge ending ISSUE; res_valid rises the following cycle.
  - Legal op 1–8 with power on: res_data←alu_out, res_op←cmd_op, res_err←0.
  - Illegal op, or power off: res_data←0, res_op←cmd_op, res_err←1.
  - NOP, PWR_ON, PWR_OFF, ALU_RESET: produce no result.
- Result handshake: res_valid clears on res_valid && res_ready unless a new capture occurs on the same edge. Outputs hold stable while res_valid && !res_ready.
- Throughput: at most one command per 2 cycles. Commands are issued and results returned strictly in FIFO order.
- Arithmetic is performed by the ALU, modulo 2^N; the sequencer never modifies alu_out.
- Boundary cases:
  - FIFO pointers wrap modulo DEPTH.
  - Empty FIFO: the FSM stays in IDLE.
  - Async reset mid-ISSUE: the pulse is cut immediately, the pending result is discarded, and the FIFO is flushed.

Decomposition:
- Shared include alu_defs.vh: opcode constants NOP..MULT, cmd_kind constants, FSM state encodings. The ALU testbench uses the same opcode constants.
- One sub-module, cmd_fifo: synchronous FIFO with parameters (width = 2+4+N, DEPTH). Outputs: full, empty, count. Head data is read out combinationally.

Test Plan:
1. Reset, ALU_RESET, OP LOAD 0x05, OP ADD 0x03, against a real ALU instance → alu_rst high exactly 1 cycle; issues spaced 2 cycles; results 0x05 then 0x08 with res_err=0.
2. PWR_OFF, then OP ADD 0x10 → alu_op never shows ADD; result res_err=1, res_data=0x00; pwr_state=0. Then PWR_ON, OP ADD 0x02 → result is prior accumulator + 0x02.
3. OP with cmd_op=4'b1010 → no ALU pulse; res_err=1, res_op=1010.
4. res_ready=0, push 6 OP LOADs back-to-back → cmd_ready drops once FIFO count reaches DEPTH. After the first issue the FSM stalls in IDLE with res_valid=1 and later commands are held. Raising res_ready drains all results in order.
5. Assert rst during an ISSUE cycle carrying alu_on=1 → alu_on, res_valid and busy drop asynchronously; cmd_ready=1; pwr_state=0.
6. LOAD 0x20, MULT 0x10 → 0x00 (wraps). Then SUB 0x01 → 0xFF.
